lockable_reg_bank: RTL and testbench

Parametrised bank of N_REGS write-once-lockable configuration registers. It generalises the single lock-protected register to many registers with:
- per-register sticky locks
- a two-phase (arm/commit) global lock with a timeout
- a registered read port
- an error pulse on blocked writes

It sits behind the security-critical configuration bus. scan_mode and debug_unlocked never bypass any lock.

---
 rtl/lockable_reg_pkg.sv | 12 +
 rtl/lockable_reg_bank_global_lock_fsm.sv | 65 ++++++
 rtl/lockable_reg_bank.sv | 114 +++++++++++
 tb/tb_lockable_reg_bank.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lockable_reg_pkg.sv
// Shared types and constants for the lockable configuration register bank.
package lockable_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  localparam int VIOL_W = 8;

endpackage

// File: rtl/lockable_reg_bank_global_lock_fsm.sv
// Two-phase (arm/commit) global lock with arm timeout; LOCKED is terminal until reset.
module global_lock_fsm
  import lockable_reg_pkg::*;
#(
  parameter int ARM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic commit,
  output logic locked
);

  localparam int TMR_W = $clog2(ARM_TIMEOUT + 1);

  lock_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // A commit in the same cycle as a re-arm still completes the lock.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          timer_d = '0;
        end
      end
      ARMED: begin
        if (commit && (timer_q < TMR_W'(ARM_TIMEOUT))) begin
          state_d = LOCKED;
          timer_d = '0;
        end else if (arm) begin
          timer_d = '0;
        end else if (timer_q >= TMR_W'(ARM_TIMEOUT - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: rtl/lockable_reg_bank.sv
// Bank of write-once-lockable configuration registers with a global arm/commit lock.
// Optional LOCK_VIOLATION_COUNT_EN adds a saturating locked-write violation counter.
module lockable_reg_bank
  import lockable_reg_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                N_REGS      = 8,
  parameter int                ADDR_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  parameter int                ARM_TIMEOUT = 16,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock_req,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              lock_all_arm,
  input  logic              lock_all_commit,
  input  logic              scan_mode,
  input  logic              debug_unlocked,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [N_REGS-1:0] lock_status,
`ifdef LOCK_VIOLATION_COUNT_EN
  output logic [VIOL_W-1:0] viol_count,
  output logic              viol_sticky,
`endif
  output logic              global_locked,
  output logic              wr_err
);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [N_REGS-1:0] lock_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_err_q, wr_err_d;

  logic [N_REGS-1:0] wr_sel, lock_sel;
  logic              wr_in_range, wr_locked, wr_same_lock, wr_accept;

  // Test and debug controls are deliberately left out of every decision.
  logic unused_dbg;
  assign unused_dbg = &{1'b0, scan_mode, debug_unlocked};

  global_lock_fsm #(
    .ARM_TIMEOUT(ARM_TIMEOUT)
  ) u_global_lock (
    .clk   (clk),
    .reset (reset),
    .arm   (lock_all_arm),
    .commit(lock_all_commit),
    .locked(global_locked)
  );

  assign lock_status = lock_q | {N_REGS{global_locked}};

  // One-hot decodes; an out-of-range address yields an all-zero select.
  always_comb begin
    wr_sel    = '0;
    lock_sel  = '0;
    rd_data_d = '0;
    for (int i = 0; i < N_REGS; i++) begin
      wr_sel[i]   = (wr_addr == ADDR_W'(i));
      lock_sel[i] = lock_req && (lock_addr == ADDR_W'(i));
      if (rd_addr == ADDR_W'(i)) rd_data_d = regs_q[i];
    end
  end

  assign wr_in_range  = |wr_sel;
  assign wr_locked    = |(wr_sel & lock_status);
  assign wr_same_lock = |(wr_sel & lock_sel);
  assign wr_accept    = wr_en && wr_in_range && !wr_locked && !wr_same_lock;
  assign wr_err_d     = wr_en && !wr_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= RESET_VAL;
      lock_q    <= '0;
      rd_data_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (wr_accept && wr_sel[i]) regs_q[i] <= wr_data;
      end
      lock_q    <= lock_q | lock_sel;
      rd_data_q <= rd_data_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign rd_data = rd_data_q;
  assign wr_err  = wr_err_q;

`ifdef LOCK_VIOLATION_COUNT_EN
  logic [VIOL_W-1:0] viol_count_q;
  logic              viol_sticky_q;

  // Only writes hitting an already-locked register count as violations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      viol_count_q  <= '0;
      viol_sticky_q <= 1'b0;
    end else if (wr_en && wr_locked) begin
      if (viol_count_q != '1) viol_count_q <= viol_count_q + 1'b1;
      viol_sticky_q <= 1'b1;
    end
  end

  assign viol_count  = viol_count_q;
  assign viol_sticky = viol_sticky_q;
`endif

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Directed self-checking bench for lockable_reg_bank (N_REGS=6 so addresses 6,7 are out of range).
module tb_lockable_reg_bank;

  localparam int DATA_W      = 16;
  localparam int N_REGS      = 6;
  localparam int ADDR_W      = 3;
  localparam int ARM_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              lock_req;
  logic [ADDR_W-1:0] lock_addr;
  logic              lock_all_arm;
  logic              lock_all_commit;
  logic              scan_mode;
  logic              debug_unlocked;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [N_REGS-1:0] lock_status;
  logic              global_locked;
  logic              wr_err;
`ifdef LOCK_VIOLATION_COUNT_EN
  logic [7:0]        viol_count;
  logic              viol_sticky;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] rdv;

  always #5 clk = ~clk;

  lockable_reg_bank #(
    .DATA_W     (DATA_W),
    .N_REGS     (N_REGS),
    .ADDR_W     (ADDR_W),
    .ARM_TIMEOUT(ARM_TIMEOUT),
    .RESET_VAL  ('0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .lock_req       (lock_req),
    .lock_addr      (lock_addr),
    .lock_all_arm   (lock_all_arm),
    .lock_all_commit(lock_all_commit),
    .scan_mode      (scan_mode),
    .debug_unlocked (debug_unlocked),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .lock_status    (lock_status),
`ifdef LOCK_VIOLATION_COUNT_EN
    .viol_count     (viol_count),
    .viol_sticky    (viol_sticky),
`endif
    .global_locked  (global_locked),
    .wr_err         (wr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change #1 after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic lock(input logic [ADDR_W-1:0] a);
    lock_req = 1'b1; lock_addr = a;
    tick();
    lock_req = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    lock_req = 1'b0; lock_addr = '0; lock_all_arm = 1'b0; lock_all_commit = 1'b0;
    scan_mode = 1'b0; debug_unlocked = 1'b0; rd_addr = '0;
    idle(2);
    check("rst_rd_data", rd_data, 0);
    check("rst_lock_status", lock_status, 0);
    check("rst_global", global_locked, 0);
    check("rst_wr_err", wr_err, 0);
    reset = 1'b0;
    tick();

    // Basic write and read-back
    write(3, 16'hBEEF);
    check("t1_wr_err", wr_err, 0);
    rd(3, rdv);
    check("t1_rd_reg3", rdv, 16'hBEEF);
    check("t1_lock_status", lock_status, 0);

    // Per-register lock blocks writes; other registers unaffected
    lock(3);
    check("t2_lock_status", lock_status, 6'b001000);
    write(3, 16'h1234);
    check("t2_wr_err_pulse", wr_err, 1);
    tick();
    check("t2_wr_err_clear", wr_err, 0);
    rd(3, rdv);
    check("t2_rd_reg3", rdv, 16'hBEEF);
    write(4, 16'h5555);
    check("t2_wr4_err", wr_err, 0);
    rd(4, rdv);
    check("t2_rd_reg4", rdv, 16'h5555);

    // Same-cycle write and read return the old value
    rd_addr = 5;
    write(5, 16'h0F0F);
    check("rw_same_old", rd_data, 0);
    tick();
    check("rw_same_new", rd_data, 16'h0F0F);

    // Lock wins over a same-cycle write
    write(2, 16'h1111);
    wr_en = 1'b1; wr_addr = 2; wr_data = 16'hAAAA;
    lock_req = 1'b1; lock_addr = 2;
    tick();
    wr_en = 1'b0; lock_req = 1'b0;
    check("t3_wr_err", wr_err, 1);
    check("t3_lock_status", lock_status, 6'b001100);
    rd(2, rdv);
    check("t3_rd_reg2", rdv, 16'h1111);

    // Out-of-range write, read and lock
    write(7, 16'h7777);
    check("oor_wr_err", wr_err, 1);
    rd(6, rdv);
    check("oor_rd", rdv, 0);
    lock(7);
    check("oor_lock_ignored", lock_status, 6'b001100);

    // Scan and debug controls cannot bypass a lock
    write(0, 16'h00A5);
    write(1, 16'h2222);
    scan_mode = 1'b1; debug_unlocked = 1'b1;
    lock(0);
    write(0, 16'hFFFF);
    check("t5_dbg_wr_err", wr_err, 1);
    rd(0, rdv);
    check("t5_dbg_reg0", rdv, 16'h00A5);
    scan_mode = 1'b0; debug_unlocked = 1'b0;

    // Simultaneous arm+commit only arms; then timeout, late commit ignored
    lock_all_arm = 1'b1; lock_all_commit = 1'b1;
    tick();
    lock_all_arm = 1'b0; lock_all_commit = 1'b0;
    check("t4_arm_commit_same", global_locked, 0);
    idle(ARM_TIMEOUT);
    lock_all_commit = 1'b1;
    tick();
    lock_all_commit = 1'b0;
    tick();
    check("t4_timeout", global_locked, 0);

    // Arm then commit three cycles later engages the global lock
    lock_all_arm = 1'b1;
    tick();
    lock_all_arm = 1'b0;
    idle(2);
    lock_all_commit = 1'b1;
    tick();
    lock_all_commit = 1'b0;
    check("t4_global_locked", global_locked, 1);
    check("t4_lock_status_all", lock_status, 6'b111111);
    write(1, 16'h3333);
    check("t4_global_wr_err", wr_err, 1);
    rd(1, rdv);
    check("t4_global_reg1", rdv, 16'h2222);

    // Reset mid-ARMED aborts to IDLE and clears everything
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    lock(4);
    lock_all_arm = 1'b1;
    tick();
    lock_all_arm = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check("t5_rst_async_locks", lock_status, 0);
    tick();
    reset = 1'b0;
    lock_all_commit = 1'b1;
    tick();
    lock_all_commit = 1'b0;
    check("t5_rst_abort_arm", global_locked, 0);
    rd(1, rdv);
    check("t5_rst_reg1", rdv, 0);
    rd(3, rdv);
    check("t5_rst_reg3", rdv, 0);

`ifdef LOCK_VIOLATION_COUNT_EN
    check("viol_rst_count", viol_count, 0);
    check("viol_rst_sticky", viol_sticky, 0);
    write(6, 16'h0001);
    check("viol_oor_err", wr_err, 1);
    check("viol_oor_count", viol_count, 0);
    lock(1);
    write(1, 16'h0001);
    check("viol_first_count", viol_count, 1);
    check("viol_first_sticky", viol_sticky, 1);
    for (int i = 0; i < 299; i++) write(1, 16'(i));
    check("viol_sat_count", viol_count, 255);
    write(7, 16'h0002);
    check("viol_oor_sat_err", wr_err, 1);
    check("viol_oor_sat_count", viol_count, 255);
    check("viol_sticky_hold", viol_sticky, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
